// File: rtl/d_to_jk_counter.sv
// W-bit up/down/load counter built from JK stages, each a D flop with JK conversion logic.
// Latency: one clk edge from input change to Q. No backpressure; en=0 simply holds state.

module jk_from_d_stage (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  logic d;

  assign d = (j & ~q) | (~k & q);

  // Qb is its own flop so it never depends combinationally on q.
  always_ff @(posedge clk) begin
    if (rst) begin
      q  <= 1'b0;
      qb <= 1'b1;
    end else begin
      q  <= d;
      qb <= ~d;
    end
  end

endmodule

module d_to_jk_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [1:0]   mode,
  input  logic [W-1:0] load_data,
  output logic [W-1:0] Q,
  output logic [W-1:0] Qb,
  output logic         tc
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [W-1:0] j_sel;
  logic [W-1:0] k_sel;

  // Running AND of lower bits: stage i toggles when every stage below it is 1 (up) or 0 (down).
  always_comb begin
    logic up_all;
    logic dn_all;
    j_sel  = '0;
    k_sel  = '0;
    up_all = 1'b1;
    dn_all = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (en) begin
        case (mode)
          MODE_HOLD: begin
            j_sel[i] = 1'b0;
            k_sel[i] = 1'b0;
          end
          MODE_UP: begin
            j_sel[i] = up_all;
            k_sel[i] = up_all;
          end
          MODE_DOWN: begin
            j_sel[i] = dn_all;
            k_sel[i] = dn_all;
          end
          MODE_LOAD: begin
            j_sel[i] = load_data[i];
            k_sel[i] = ~load_data[i];
          end
          default: begin
            j_sel[i] = 1'b0;
            k_sel[i] = 1'b0;
          end
        endcase
      end
      up_all = up_all & Q[i];
      dn_all = dn_all & Qb[i];
    end
  end

  for (genvar g = 0; g < W; g++) begin : g_stage
    jk_from_d_stage u_stage (
      .clk (clk),
      .rst (rst),
      .j   (j_sel[g]),
      .k   (k_sel[g]),
      .q   (Q[g]),
      .qb  (Qb[g])
    );
  end

  assign tc = en & (((mode == MODE_UP) & (&Q)) | ((mode == MODE_DOWN) & ~(|Q)));

endmodule

// File: tb/tb_d_to_jk_counter.sv
// Directed bench for d_to_jk_counter (W=4): reset, up/down wrap, load/hold, enable gating, JK table.

module tb_d_to_jk_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] load_data;
  logic [3:0] Q;
  logic [3:0] Qb;
  logic       tc;

  int n_cmp = 0;
  int n_err = 0;
  bit inv_on = 1'b0;

  d_to_jk_counter #(.W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .load_data (load_data),
    .Q         (Q),
    .Qb        (Qb),
    .tc        (tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (inv_on) chk("qb_inv", {4'h0, Qb}, {4'h0, ~Q});
  end

  logic [3:0] down_exp [4];
  logic [3:0] jk_vals  [5];

  initial begin
    down_exp = '{4'h1, 4'h0, 4'hF, 4'hE};
    jk_vals  = '{4'h5, 4'hA, 4'h5, 4'hA, 4'hA};

    // Reset with a conflicting load pending: reset must win.
    rst = 1'b1; en = 1'b1; mode = 2'b11; load_data = 4'hF;
    step();
    inv_on = 1'b1;
    chk("rst_q",  {4'h0, Q},  8'h00);
    chk("rst_qb", {4'h0, Qb}, 8'h0F);
    chk("rst_tc", {7'h0, tc}, 8'h00);

    // Up count through wrap.
    rst = 1'b0; mode = 2'b01;
    chk("up_tc0", {7'h0, tc}, 8'h00);
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("up_q",  {4'h0, Q},  8'(i % 16));
      chk("up_tc", {7'h0, tc}, ((i % 16) == 15) ? 8'h01 : 8'h00);
    end

    // Down count through wrap.
    mode = 2'b11; load_data = 4'h2;
    step();
    chk("ld2_q",  {4'h0, Q},  8'h02);
    chk("ld2_tc", {7'h0, tc}, 8'h00);
    mode = 2'b10;
    chk("dn_tc2", {7'h0, tc}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("dn_q",  {4'h0, Q},  {4'h0, down_exp[i]});
      chk("dn_tc", {7'h0, tc}, (down_exp[i] == 4'h0) ? 8'h01 : 8'h00);
    end

    // Load then hold.
    mode = 2'b11; load_data = 4'hA;
    step();
    chk("ldA_q",  {4'h0, Q},  8'h0A);
    chk("ldA_qb", {4'h0, Qb}, 8'h05);
    mode = 2'b00;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_q",  {4'h0, Q},  8'h0A);
      chk("hold_tc", {7'h0, tc}, 8'h00);
    end

    // Enable gating.
    mode = 2'b11; load_data = 4'h7;
    step();
    chk("ld7_q", {4'h0, Q}, 8'h07);
    en = 1'b0; mode = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gate_q",  {4'h0, Q},  8'h07);
      chk("gate_tc", {7'h0, tc}, 8'h00);
    end
    en = 1'b1;
    step();
    chk("ungate_q", {4'h0, Q}, 8'h08);

    // Disabled at all-ones in up mode: tc must stay low.
    mode = 2'b11; load_data = 4'hF;
    step();
    en = 1'b0; mode = 2'b01;
    #1;
    chk("tc_en0", {7'h0, tc}, 8'h00);
    en = 1'b1;
    #1;
    chk("tc_en1", {7'h0, tc}, 8'h01);

    // Reset mid-count with a load requested.
    mode = 2'b11; load_data = 4'h8;
    step();
    mode = 2'b01;
    step();
    chk("mid_q9", {4'h0, Q}, 8'h09);
    rst = 1'b1; mode = 2'b11; load_data = 4'hF;
    step();
    chk("mid_rst_q",  {4'h0, Q},  8'h00);
    chk("mid_rst_qb", {4'h0, Qb}, 8'h0F);
    rst = 1'b0; mode = 2'b01;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("resume_q", {4'h0, Q}, 8'(i));
    end

    // JK set/reset per bit, including an identical reload.
    mode = 2'b11;
    for (int i = 0; i < 5; i++) begin
      load_data = jk_vals[i];
      step();
      chk("jk_q",  {4'h0, Q},  {4'h0, jk_vals[i]});
      chk("jk_qb", {4'h0, Qb}, {4'h0, ~jk_vals[i]});
    end

    @(negedge clk);
    inv_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
